// File: rtl/dvp_axis_pkg.sv
// Shared types and constants for the DVP to AXI4-Stream video bridge.
package dvp_axis_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACT, S_STREAM, S_DROP} state_t;

  localparam int DATA_W         = 8;
  localparam int SOF_BIT        = 9;
  localparam int EOL_BIT        = 8;
  localparam int ENTRY_W        = 10;
  localparam int PIX_W          = 11;
  localparam int LINE_W         = 10;
  localparam int HSIZE_DEF      = 1280;
  localparam int VSIZE_DEF      = 720;
  localparam int FIFO_DEPTH_DEF = 2048;
endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with a registered read port; the read register doubles as
// the stream output register of the bridge.
module axis_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 2048
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/dvp_to_axis_video.sv
// DVP (vsync/DE/data) to AXI4-Stream video: SOF on tuser, EOL on tlast, with a
// line-sized FIFO; an overflow drops the rest of the frame until the next vsync.
module dvp_to_axis_video
  import dvp_axis_pkg::*;
#(
  parameter int HSIZE      = HSIZE_DEF,
  parameter int VSIZE      = VSIZE_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic              i_vid_clk,
  input  logic              i_rst_n,
  input  logic              i_vid_hsync,
  input  logic              i_vid_vsync,
  input  logic              i_vid_active_video,
  input  logic [DATA_W-1:0] i_vid_data,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [15:0]       o_frame_cnt,
  output logic              o_overflow,
  output logic              o_line_err
);
  state_t                    state, state_nxt;
  logic                      vs_act, vs_q, vs_edge;
  logic                      hold_vld_p0, hold_sof_p0;
  logic [DATA_W-1:0]         hold_data_p0;
  logic                      cont, take, eol, wr_en, ovf_evt, eol_evt;
  logic [ENTRY_W-1:0]        wr_entry, rd_entry;
  logic                      fifo_full, fifo_empty, rd_en;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;
  logic                      hsync_unused;
  logic [PIX_W-1:0]          pix_cnt;
  logic [LINE_W-1:0]         line_cnt, line_total;

  assign hsync_unused = i_vid_hsync;
  assign vs_act  = (i_vid_vsync == SYNC_POL);
  assign vs_edge = vs_act && !vs_q;

  // The held pixel closes its line unless the stream continues this cycle.
  assign cont    = i_vid_active_video && (state == S_STREAM);
  assign eol     = !cont;
  assign ovf_evt = hold_vld_p0 && fifo_full;
  assign wr_en   = hold_vld_p0 && !fifo_full;
  assign eol_evt = wr_en && eol;
  assign take    = i_vid_active_video && !ovf_evt &&
                   ((state == S_WAIT_ACT) || (state == S_STREAM));
  assign line_total = line_cnt + LINE_W'(eol_evt);

  always_comb begin
    wr_entry               = '0;
    wr_entry[SOF_BIT]      = hold_sof_p0;
    wr_entry[EOL_BIT]      = eol;
    wr_entry[DATA_W-1:0]   = hold_data_p0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (vs_edge) state_nxt = S_WAIT_ACT;
      S_WAIT_ACT: if (ovf_evt) state_nxt = vs_edge ? S_WAIT_ACT : S_DROP;
                  else if (i_vid_active_video) state_nxt = S_STREAM;
      S_STREAM:   if (ovf_evt) state_nxt = vs_edge ? S_WAIT_ACT : S_DROP;
                  else if (vs_edge) state_nxt = S_WAIT_ACT;
      S_DROP:     if (vs_edge) state_nxt = S_WAIT_ACT;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: one-cycle pixel hold so EOL is known when the entry is written
  always_ff @(posedge i_vid_clk) begin
    if (take) begin
      hold_data_p0 <= i_vid_data;
      hold_sof_p0  <= (state == S_WAIT_ACT);
    end
  end

  always_ff @(posedge i_vid_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      vs_q          <= 1'b1;
      hold_vld_p0   <= 1'b0;
      pix_cnt       <= '0;
      line_cnt      <= '0;
      o_frame_cnt   <= '0;
      o_overflow    <= 1'b0;
      o_line_err    <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      state       <= state_nxt;
      vs_q        <= vs_act;
      hold_vld_p0 <= take;
      if ((state == S_IDLE) || (state == S_DROP)) pix_cnt <= '0;
      else pix_cnt <= (eol_evt ? '0 : pix_cnt) + PIX_W'(take);
      line_cnt    <= vs_edge ? '0 : line_total;
      if (vs_edge && (state == S_STREAM) && !ovf_evt) o_frame_cnt <= o_frame_cnt + 16'd1;
      if (ovf_evt) o_overflow <= 1'b1;
      o_line_err  <= (eol_evt && (pix_cnt != PIX_W'(HSIZE))) ||
                     (vs_edge && (state == S_STREAM) && (line_total != LINE_W'(VSIZE)));
      // Stage p1: output beat valid tracks the FIFO read register
      if (rd_en) m_axis_tvalid <= 1'b1;
      else if (m_axis_tready) m_axis_tvalid <= 1'b0;
    end
  end

  assign rd_en = !fifo_empty && (!m_axis_tvalid || m_axis_tready);

  axis_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_vid_clk),
    .rst_n   (i_rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_unused)
  );

  assign m_axis_tdata = rd_entry[DATA_W-1:0];
  assign m_axis_tuser = rd_entry[SOF_BIT];
  assign m_axis_tlast = rd_entry[EOL_BIT];
endmodule

// File: tb/tb_dvp_to_axis_video.sv
// Scoreboard bench for dvp_to_axis_video on a reduced 16x4 raster.
module tb_dvp_to_axis_video;
  localparam int HS    = 16;
  localparam int VS    = 4;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        active = 1'b0;
  logic [7:0]  data = 8'd0;
  logic [7:0]  tdata;
  logic        tvalid, tuser, tlast;
  logic        tready = 1'b1;
  logic [15:0] frame_cnt;
  logic        overflow, line_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [9:0] sb[$];
  int err_pulses = 0;
  int stall_left = 0;
  bit rand_rdy = 1'b0;
  int exp_frames = 0;
  bit pending = 1'b0;
  bit lat_arm = 1'b0;
  int lat_cyc = -1;
  int first_pix_cyc = -100;
  int e0;

  always #5 clk = ~clk;

  dvp_to_axis_video #(
    .HSIZE(HS), .VSIZE(VS), .FIFO_DEPTH(DEPTH), .SYNC_POL(1'b0)
  ) dut (
    .i_vid_clk          (clk),
    .i_rst_n            (rst_n),
    .i_vid_hsync        (hsync),
    .i_vid_vsync        (vsync),
    .i_vid_active_video (active),
    .i_vid_data         (data),
    .m_axis_tdata       (tdata),
    .m_axis_tvalid      (tvalid),
    .m_axis_tuser       (tuser),
    .m_axis_tlast       (tlast),
    .m_axis_tready      (tready),
    .o_frame_cnt        (frame_cnt),
    .o_overflow         (overflow),
    .o_line_err         (line_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero();
    check("rst_tvalid", 32'(tvalid), 0);
    check("rst_tdata", 32'(tdata), 0);
    check("rst_tuser", 32'(tuser), 0);
    check("rst_tlast", 32'(tlast), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_line_err", 32'(line_err), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (stall_left > 0) begin
      tready = 1'b0;
      stall_left--;
    end else if (rand_rdy) begin
      tready = ($urandom_range(0, 9) < 7);
    end else begin
      tready = 1'b1;
    end
  endtask

  task automatic monitor();
    logic [9:0] beat;
    logic [9:0] held = '0;
    bit stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (line_err) err_pulses++;
        if (lat_arm && tvalid) begin
          lat_cyc = cyc;
          lat_arm = 1'b0;
        end
        beat = {tuser, tlast, tdata};
        if (stalled) check("stall_hold", {21'd0, tvalid, beat}, {21'd0, 1'b1, held});
        if (tvalid && tready) begin
          if (sb.size() == 0) check("unexpected_beat", 32'(sb.size()), 1);
          else check("beat", 32'(beat), 32'(sb.pop_front()));
        end
        stalled = tvalid && !tready;
        held = beat;
      end
    end
  endtask

  task automatic vsync_pulse();
    for (int i = 0; i < 3; i++) begin
      tick();
      vsync = 1'b0;
      active = 1'b0;
      if (i == 0 && pending) begin
        exp_frames++;
        pending = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vsync = 1'b1;
    end
  endtask

  // mode 0: frame expected complete and counted; mode 1: frame expected dropped
  task automatic drive_frame(input int nlines, input int short_line, input int short_len,
                             input int stall_line, input int stall_len, input int rst_line,
                             input int mode);
    int len;
    bit exp_on;
    exp_on = 1'b1;
    vsync_pulse();
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_line) ? short_len : HS;
      for (int i = 0; i < 5; i++) begin
        tick();
        active = 1'b0;
        hsync = (i < 2) ? 1'b0 : 1'b1;
      end
      for (int p = 0; p < len; p++) begin
        if (l == stall_line && p == HS / 2) stall_left = stall_len;
        if (l == rst_line && p == HS / 2) begin
          check("frame_cnt_pre_reset", 32'(frame_cnt), 32'(exp_frames));
          tick();
          active = 1'b0;
          rst_n = 1'b0;
          sb.delete();
          exp_on = 1'b0;
          exp_frames = 0;
          #1;
          check_outputs_zero();
          repeat (4) tick();
          tick();
          rst_n = 1'b1;
        end
        tick();
        active = 1'b1;
        data = 8'($urandom_range(0, 255));
        if (lat_arm && l == 0 && p == 0) first_pix_cyc = cyc;
        if (exp_on) sb.push_back({(l == 0 && p == 0), (p == len - 1), data});
      end
      for (int i = 0; i < 5; i++) begin
        tick();
        active = 1'b0;
      end
    end
    for (int i = 0; i < 6; i++) tick();
    pending = exp_on && (mode == 0);
  endtask

  task automatic drain(input bit truncated);
    int idle;
    idle = 0;
    for (int i = 0; i < 400 && idle < 8; i++) begin
      tick();
      idle = (tvalid || (!truncated && sb.size() != 0)) ? 0 : idle + 1;
    end
    if (truncated) check("drop_truncated", 32'(sb.size() > 0), 1);
    else check("sb_empty", 32'(sb.size()), 0);
    sb.delete();
  endtask

  initial begin
    fork
      monitor();
    join_none
    rst_n = 1'b0;
    repeat (3) tick();
    check_outputs_zero();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();

    lat_arm = 1'b1;
    drive_frame(VS, -1, 0, -1, 0, -1, 0);
    check("latency", 32'(lat_cyc - first_pix_cyc), 3);

    drive_frame(VS, -1, 0, 2, 20, -1, 0);
    check("frame_cnt_1", 32'(frame_cnt), 32'(exp_frames));
    check("no_overflow", 32'(overflow), 0);
    drain(1'b0);

    drive_frame(VS, -1, 0, 1, 60, -1, 1);
    drain(1'b1);
    check("overflow_set", 32'(overflow), 1);
    check("frame_cnt_drop", 32'(frame_cnt), 32'(exp_frames));

    drive_frame(VS, -1, 0, -1, 0, -1, 0);

    e0 = err_pulses;
    drive_frame(VS, 1, 10, -1, 0, -1, 0);
    check("line_err_short", 32'(err_pulses - e0), 1);
    e0 = err_pulses;
    drive_frame(VS - 1, -1, 0, -1, 0, -1, 0);
    check("line_err_none", 32'(err_pulses - e0), 0);
    e0 = err_pulses;
    drive_frame(VS, -1, 0, -1, 0, -1, 0);
    check("line_err_vsize", 32'(err_pulses - e0), 1);
    check("frame_cnt_5", 32'(frame_cnt), 32'(exp_frames));

    drive_frame(VS, -1, 0, -1, 0, 2, 0);
    drain(1'b0);
    check("frame_cnt_after_reset", 32'(frame_cnt), 32'(exp_frames));
    check("overflow_cleared", 32'(overflow), 0);

    drive_frame(VS, -1, 0, -1, 0, -1, 0);
    rand_rdy = 1'b1;
    for (int f = 0; f < 3; f++) drive_frame(VS, -1, 0, -1, 0, -1, 0);
    vsync_pulse();
    drain(1'b0);
    check("frame_cnt_final", 32'(frame_cnt), 32'(exp_frames));
    check("overflow_final", 32'(overflow), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
